// File: rtl/ir_queue.sv
// Instruction-register queue: a DEPTH-entry circular buffer of 32-bit words
// whose head word is decoded into MIPS-style fields.
//
// Handshake: a push is taken when ir_write=1, full=0 and flush=0; a pop is
// taken when ir_read=1, valid=1 and flush=0. A push while full is dropped and
// reported by a one-cycle overflow pulse. flush overrides both.
module ir_queue #(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ir_write,
  input  logic [31:0]                write_data,
  input  logic                       ir_read,
  output logic                       full,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                address_immediate,
  output logic [25:0]                jump_target
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push_ok, pop_ok;
  logic [31:0]   head_word;

  // Status comes only from the registered count, never from this cycle's inputs.
  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign count = count_q;
  assign overflow = overflow_q;

  assign push_ok = ir_write && !full && !flush;
  assign pop_ok  = ir_read && valid && !flush;

  // Pointers are power-of-two wide, so natural rollover gives the wrap.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = ir_write && full && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the count alone decides which words are live.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= write_data;
  end

  assign head_word = valid ? mem_q[rd_ptr_q] : RESET_INSTR;

  assign opcode            = head_word[31:26];
  assign rs                = head_word[25:21];
  assign rt                = head_word[20:16];
  assign rd                = head_word[15:11];
  assign shamt             = head_word[10:6];
  assign funct             = head_word[5:0];
  assign address_immediate = head_word[15:0];
  assign jump_target       = head_word[25:0];

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_ir_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_W = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ir_write = 1'b0;
  logic [31:0] write_data = '0;
  logic        ir_read = 1'b0;
  logic        full, valid, overflow;
  logic [2:0]  count;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] address_immediate;
  logic [25:0] jump_target;

  ir_queue #(.DEPTH(DEPTH), .RESET_INSTR(RST_W)) dut (
    .clock(clock), .reset(reset), .flush(flush), .ir_write(ir_write),
    .write_data(write_data), .ir_read(ir_read), .full(full), .valid(valid),
    .count(count), .overflow(overflow), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct),
    .address_immediate(address_immediate), .jump_target(jump_target)
  );

  always #5 clock = ~clock;

  // Reference model: the live words in order, plus the overflow flag.
  logic [31:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : RST_W;
  endfunction

  task automatic model_edge(input logic w, input logic [31:0] d, input logic r, input logic f);
    bit was_full;
    bit was_empty;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    if (f) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      exp_ovf = w && was_full;
      if (r && !was_empty) void'(exp_q.pop_front());
      if (w && !was_full) exp_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    logic [31:0] h;
    h = exp_head();
    chk("count",    32'(count),    32'(exp_q.size()));
    chk("valid",    32'(valid),    32'(exp_q.size() != 0));
    chk("full",     32'(full),     32'(exp_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("opcode",   32'(opcode),   32'(h[31:26]));
    chk("rs",       32'(rs),       32'(h[25:21]));
    chk("rt",       32'(rt),       32'(h[20:16]));
    chk("rd",       32'(rd),       32'(h[15:11]));
    chk("shamt",    32'(shamt),    32'(h[10:6]));
    chk("funct",    32'(funct),    32'(h[5:0]));
    chk("imm",      32'(address_immediate), 32'(h[15:0]));
    chk("jtarget",  32'(jump_target),       32'(h[25:0]));
  endtask

  always @(negedge clock) if (chk_en) compare_all();

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
    ir_write = w; write_data = d; ir_read = r; flush = f;
    @(posedge clock);
    model_edge(w, d, r, f);
    #1;
    ir_write = 1'b0; ir_read = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'h37);
    #11 reset = 1'b0;
    chk_en = 1'b1;

    // Single push and decode.
    step(1, 32'h8C22_0004, 0, 0);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_opcode", 32'(opcode), 32'h23);
    chk("p1_rs", 32'(rs), 32'd1);
    chk("p1_rt", 32'(rt), 32'd2);
    chk("p1_imm", 32'(address_immediate), 32'h0004);
    step(0, 0, 1, 0);

    // Five pushes into a 4-deep queue, then drain.
    for (int i = 0; i < 5; i++) step(1, 32'h1000_0000 + 32'(i), 0, 0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    step(0, 0, 0, 0);
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(jump_target), 32'(i));
      step(0, 0, 1, 0);
    end

    // Full with simultaneous push and pop, wrapping pointers.
    for (int i = 0; i < 4; i++) step(1, 32'h2000_0000 + 32'(i), 0, 0);
    step(1, 32'h3000_0000, 1, 0);
    chk("fpp_count", 32'(count), 32'd3);
    chk("fpp_ovf", 32'(overflow), 32'd1);
    chk("fpp_head", 32'(jump_target), 32'h0000_0001);
    step(1, 32'h3000_0001, 1, 0);
    step(1, 32'h3000_0002, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Empty queue, push and pop together.
    step(1, 32'h0000_0020, 1, 0);
    chk("epp_count", 32'(count), 32'd1);
    chk("epp_funct", 32'(funct), 32'h20);
    step(1, 32'h0000_0021, 0, 0);
    step(1, 32'h0000_0022, 0, 0);

    // Three entries, flush wins over a push.
    step(1, 32'hFFFF_FFFF, 0, 1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(valid), 32'd0);
    chk("fl_funct", 32'(funct), 32'(RST_W[5:0]));
    chk("fl_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset between edges with two entries held.
    step(1, 32'h4000_0001, 0, 0);
    step(1, 32'h4000_0002, 0, 0);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_imm", 32'(address_immediate), 32'(RST_W[15:0]));
    exp_q.delete();
    exp_ovf = 1'b0;
    #3 reset = 1'b0;
    chk_en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 4);
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
